pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, width of write-data and instruction/PC fields.
REQ-002 The block SHALL have parameter ADDR_W, default 5, width of the GRF write address.
REQ-003 The block SHALL have parameter TNEW_W, default 2, width of the Tnew field.
REQ-004 The block SHALL have parameter TNEW_DEC, default 1: 1 = saturating decrement of Tnew on load, 0 = pass through.
REQ-005 The block SHALL have parameter KEEP_PC_ON_FLUSH, default 1: 1 = a flush loads pc_in and bd_in, 0 = a flush clears them.
REQ-006 The block SHALL have ports: clk in 1, system clock; reset in 1, asynchronous active-high reset.
REQ-007 The block SHALL have ports: en in 1, advance stage; flush in 1, load a bubble.
REQ-008 The block SHALL have ports: valid_in/valid_out 1, instr_in/instr_out DATA_W, pc_in/pc_out DATA_W.
REQ-009 The block SHALL have ports: waddr_in/waddr_out ADDR_W, wdata_in/wdata_out DATA_W, regwrite_in/regwrite_out 1.
REQ-010 The block SHALL have ports: tnew_in/tnew_out TNEW_W, exc_in/exc_out 5 (exception code), bd_in/bd_out 1 (branch-delay flag).
REQ-011 The block SHALL have port hold_cnt out 8, count of consecutive cycles held.

Function
REQ-012 All state SHALL change only on posedge clk, except on reset.
REQ-013 Priority per edge SHALL be: reset > flush > hold (en=0) > load (en=1).
REQ-014 Load: each field SHALL register its _in value one cycle later.
REQ-015 Load with TNEW_DEC=1: tnew SHALL register (tnew_in==0) ? 0 : tnew_in-1.
REQ-016 Load with TNEW_DEC=0: tnew SHALL register tnew_in.
REQ-017 Hold: all fields SHALL keep their values, Tnew not decremented.
REQ-018 Flush: valid, instr, waddr, wdata, regwrite, tnew and exc SHALL register 0, regardless of en.
REQ-019 Flush with KEEP_PC_ON_FLUSH=1: pc and bd SHALL register pc_in and bd_in; with 0 they SHALL register 0.
REQ-020 regwrite_out SHALL be 1 only when the stored regwrite=1, stored valid=1 and stored waddr!=0.
REQ-021 wdata_out and waddr_out SHALL output stored values unmasked.
REQ-022 hold_cnt SHALL become 0 on load or flush.
REQ-023 hold_cnt SHALL increment by 1 on each hold and saturate at 255, with no wrap.
REQ-024 Outputs SHALL be driven directly from registers, except regwrite_out, which is the masking AND gate only.
REQ-025 When flush and en are both 1, the bubble SHALL win and the input instruction SHALL be discarded.

Reset
REQ-026 Asserting reset SHALL immediately clear every field and hold_cnt to 0, asynchronously, independent of clk.
REQ-027 Reset asserted mid-hold SHALL clear hold_cnt and data.
REQ-028 The first edge after reset deassertion SHALL follow REQ-013.
REQ-029 During reset, regwrite_out SHALL be 0 and valid_out SHALL be 0.

Verification
REQ-030 Load: en=1, instr_in=0x00432021, pc_in=0x3004, waddr_in=4, regwrite_in=1, valid_in=1, tnew_in=2 -> next cycle instr_out=0x00432021, pc_out=0x3004, regwrite_out=1, tnew_out=1; tnew_in=0 -> tnew_out=0.
REQ-031 Hold: after a load, en=0 for 300 cycles with changing inputs -> outputs unchanged, tnew unchanged, hold_cnt 1,2,...,255 then stays at 255; next en=1 -> hold_cnt=0.
REQ-032 Flush: flush=1, en=1, pc_in=0x3010, bd_in=1, exc_in=4 -> instr_out=0, valid_out=0, exc_out=0, pc_out=0x3010, bd_out=1 (KEEP_PC_ON_FLUSH=1); with KEEP_PC_ON_FLUSH=0 -> pc_out=0, bd_out=0.
REQ-033 $0 mask: load waddr_in=0, regwrite_in=1, valid_in=1, wdata_in=0xDEADBEEF -> regwrite_out=0, wdata_out=0xDEADBEEF.
REQ-034 Async reset: loaded state with hold_cnt=7, assert reset between edges -> all outputs 0 before the next clk edge.
REQ-035 Parameters: DATA_W=64, TNEW_W=3, TNEW_DEC=0, tnew_in=5 -> tnew_out=5, 64-bit wdata_in passes through intact.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying one instruction's fields between stages.
// It supports stall (hold), bubble insertion (flush), Tnew aging and a stall-length counter.
module pipe_stage_reg #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 5,
    parameter int TNEW_W           = 2,
    parameter int TNEW_DEC         = 1,
    parameter int KEEP_PC_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] waddr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              regwrite_in,
    input  logic [TNEW_W-1:0] tnew_in,
    input  logic [4:0]        exc_in,
    input  logic              bd_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [ADDR_W-1:0] waddr_out,
    output logic [DATA_W-1:0] wdata_out,
    output logic              regwrite_out,
    output logic [TNEW_W-1:0] tnew_out,
    output logic [4:0]        exc_out,
    output logic              bd_out,
    output logic [7:0]        hold_cnt
);

    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_regwrite;
    logic [TNEW_W-1:0] r_tnew;
    logic [4:0]        r_exc;
    logic              r_bd;
    logic [7:0]        r_hold_cnt;

    logic [TNEW_W-1:0] w_tnew_load;
    logic [DATA_W-1:0] w_flush_pc;
    logic              w_flush_bd;
    logic [7:0]        w_hold_cnt_inc;

    // Tnew counts down one stage per advance and never underflows.
    assign w_tnew_load = (TNEW_DEC != 0)
                       ? ((tnew_in == '0) ? '0 : tnew_in - 1'b1)
                       : tnew_in;

    // A bubble may keep the PC/delay-slot flag so exception handling still sees the victim's PC.
    assign w_flush_pc = (KEEP_PC_ON_FLUSH != 0) ? pc_in : '0;
    assign w_flush_bd = (KEEP_PC_ON_FLUSH != 0) ? bd_in : 1'b0;

    assign w_hold_cnt_inc = (r_hold_cnt == 8'hFF) ? r_hold_cnt : r_hold_cnt + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_pc       <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_regwrite <= 1'b0;
            r_tnew     <= '0;
            r_exc      <= '0;
            r_bd       <= 1'b0;
            r_hold_cnt <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_pc       <= w_flush_pc;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_regwrite <= 1'b0;
            r_tnew     <= '0;
            r_exc      <= '0;
            r_bd       <= w_flush_bd;
            r_hold_cnt <= '0;
        end else if (!en) begin
            r_hold_cnt <= w_hold_cnt_inc;
        end else begin
            r_valid    <= valid_in;
            r_instr    <= instr_in;
            r_pc       <= pc_in;
            r_waddr    <= waddr_in;
            r_wdata    <= wdata_in;
            r_regwrite <= regwrite_in;
            r_tnew     <= w_tnew_load;
            r_exc      <= exc_in;
            r_bd       <= bd_in;
            r_hold_cnt <= '0;
        end
    end

    assign valid_out = r_valid;
    assign instr_out = r_instr;
    assign pc_out    = r_pc;
    assign waddr_out = r_waddr;
    assign wdata_out = r_wdata;
    assign tnew_out  = r_tnew;
    assign exc_out   = r_exc;
    assign bd_out    = r_bd;
    assign hold_cnt  = r_hold_cnt;

    // Writes to $0 or from bubbles never reach the register file.
    assign regwrite_out = r_regwrite & r_valid & (r_waddr != '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default build, PC-clearing flush build, and a 64-bit
// pass-through Tnew build, all sharing clock, reset and control.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic        valid_in;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic [4:0]  waddr_in;
  logic [31:0] wdata_in;
  logic        regwrite_in;
  logic [1:0]  tnew_in;
  logic [4:0]  exc_in;
  logic        bd_in;

  logic        a_valid, a_regwrite, a_bd;
  logic [31:0] a_instr, a_pc, a_wdata;
  logic [4:0]  a_waddr, a_exc;
  logic [1:0]  a_tnew;
  logic [7:0]  a_hold;

  logic        b_valid, b_regwrite, b_bd;
  logic [31:0] b_instr, b_pc, b_wdata;
  logic [4:0]  b_waddr, b_exc;
  logic [1:0]  b_tnew;
  logic [7:0]  b_hold;

  logic [63:0] c_instr_in, c_pc_in, c_wdata_in;
  logic [2:0]  c_tnew_in;
  logic        c_valid, c_regwrite, c_bd;
  logic [63:0] c_instr, c_pc, c_wdata;
  logic [4:0]  c_waddr, c_exc;
  logic [2:0]  c_tnew;
  logic [7:0]  c_hold;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg dut_a (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in), .waddr_in(waddr_in),
    .wdata_in(wdata_in), .regwrite_in(regwrite_in), .tnew_in(tnew_in), .exc_in(exc_in),
    .bd_in(bd_in),
    .valid_out(a_valid), .instr_out(a_instr), .pc_out(a_pc), .waddr_out(a_waddr),
    .wdata_out(a_wdata), .regwrite_out(a_regwrite), .tnew_out(a_tnew), .exc_out(a_exc),
    .bd_out(a_bd), .hold_cnt(a_hold)
  );

  pipe_stage_reg #(.KEEP_PC_ON_FLUSH(0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in), .waddr_in(waddr_in),
    .wdata_in(wdata_in), .regwrite_in(regwrite_in), .tnew_in(tnew_in), .exc_in(exc_in),
    .bd_in(bd_in),
    .valid_out(b_valid), .instr_out(b_instr), .pc_out(b_pc), .waddr_out(b_waddr),
    .wdata_out(b_wdata), .regwrite_out(b_regwrite), .tnew_out(b_tnew), .exc_out(b_exc),
    .bd_out(b_bd), .hold_cnt(b_hold)
  );

  pipe_stage_reg #(.DATA_W(64), .TNEW_W(3), .TNEW_DEC(0)) dut_c (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .valid_in(valid_in), .instr_in(c_instr_in), .pc_in(c_pc_in), .waddr_in(waddr_in),
    .wdata_in(c_wdata_in), .regwrite_in(regwrite_in), .tnew_in(c_tnew_in), .exc_in(exc_in),
    .bd_in(bd_in),
    .valid_out(c_valid), .instr_out(c_instr), .pc_out(c_pc), .waddr_out(c_waddr),
    .wdata_out(c_wdata), .regwrite_out(c_regwrite), .tnew_out(c_tnew), .exc_out(c_exc),
    .bd_out(c_bd), .hold_cnt(c_hold)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle for sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [31:0] instr, input logic [31:0] pc,
                            input logic [4:0] waddr, input logic [31:0] wdata,
                            input logic [1:0] tnew);
    en = 1'b1; flush = 1'b0; valid_in = 1'b1; regwrite_in = 1'b1;
    instr_in = instr; pc_in = pc; waddr_in = waddr; wdata_in = wdata;
    tnew_in = tnew; exc_in = 5'd0; bd_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0; valid_in = 1'b0; instr_in = '0; pc_in = '0;
    waddr_in = '0; wdata_in = '0; regwrite_in = 1'b0; tnew_in = '0; exc_in = '0; bd_in = 1'b0;
    c_instr_in = '0; c_pc_in = '0; c_wdata_in = '0; c_tnew_in = '0;

    // reset state
    repeat (2) step();
    chk("rst_valid", {63'd0, a_valid}, 64'd0);
    chk("rst_regwrite", {63'd0, a_regwrite}, 64'd0);
    chk("rst_instr", {32'd0, a_instr}, 64'd0);
    chk("rst_hold", {56'd0, a_hold}, 64'd0);
    reset = 1'b0;

    // basic load with Tnew decrement; 64-bit instance passes Tnew through
    drive_load(32'h00432021, 32'h3004, 5'd4, 32'h1234_5678, 2'd2);
    c_wdata_in = 64'h0123_4567_89AB_CDEF; c_tnew_in = 3'd5; c_instr_in = 64'hFEDC_BA98_7654_3210;
    step();
    chk("ld_instr", {32'd0, a_instr}, 64'h00432021);
    chk("ld_pc", {32'd0, a_pc}, 64'h3004);
    chk("ld_regwrite", {63'd0, a_regwrite}, 64'd1);
    chk("ld_tnew", {62'd0, a_tnew}, 64'd1);
    chk("ld_valid", {63'd0, a_valid}, 64'd1);
    chk("ld_waddr", {59'd0, a_waddr}, 64'd4);
    chk("c_tnew", {61'd0, c_tnew}, 64'd5);
    chk("c_wdata", c_wdata, 64'h0123_4567_89AB_CDEF);
    chk("c_instr", c_instr, 64'hFEDC_BA98_7654_3210);

    tnew_in = 2'd0; c_tnew_in = 3'd0;
    step();
    chk("ld_tnew0", {62'd0, a_tnew}, 64'd0);
    chk("c_tnew0", {61'd0, c_tnew}, 64'd0);

    // writes to $0 are masked, data still visible
    drive_load(32'h0000_0020, 32'h3008, 5'd0, 32'hDEADBEEF, 2'd1);
    step();
    chk("z_regwrite", {63'd0, a_regwrite}, 64'd0);
    chk("z_wdata", {32'd0, a_wdata}, 64'hDEADBEEF);
    chk("z_waddr", {59'd0, a_waddr}, 64'd0);
    chk("z_tnew", {62'd0, a_tnew}, 64'd0);

    // invalid instruction with regwrite is masked too
    drive_load(32'h0000_0021, 32'h300C, 5'd7, 32'h5, 2'd3);
    valid_in = 1'b0;
    step();
    chk("inv_regwrite", {63'd0, a_regwrite}, 64'd0);
    chk("inv_tnew", {62'd0, a_tnew}, 64'd2);

    // long hold with changing inputs, counter saturates
    drive_load(32'h00432021, 32'h3004, 5'd4, 32'hCAFE_0001, 2'd2);
    step();
    en = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      instr_in = $urandom; pc_in = $urandom; wdata_in = $urandom;
      waddr_in = 5'($urandom_range(0, 31)); tnew_in = 2'($urandom_range(0, 3));
      valid_in = 1'($urandom_range(0, 1));
      step();
      chk($sformatf("hold_cnt_%0d", i), {56'd0, a_hold}, (i > 255) ? 64'd255 : 64'(i));
      chk($sformatf("hold_instr_%0d", i), {32'd0, a_instr}, 64'h00432021);
    end
    chk("hold_pc", {32'd0, a_pc}, 64'h3004);
    chk("hold_tnew", {62'd0, a_tnew}, 64'd1);
    chk("hold_wdata", {32'd0, a_wdata}, 64'hCAFE_0001);
    chk("hold_regwrite", {63'd0, a_regwrite}, 64'd1);
    drive_load(32'h1111_2222, 32'h3008, 5'd3, 32'h9, 2'd1);
    step();
    chk("unhold_cnt", {56'd0, a_hold}, 64'd0);
    chk("unhold_instr", {32'd0, a_instr}, 64'h1111_2222);

    // flush beats en; PC kept in A, cleared in B
    en = 1'b0; step(); step();
    chk("pre_flush_hold", {56'd0, a_hold}, 64'd2);
    drive_load(32'hABCD_0001, 32'h3010, 5'd5, 32'h77, 2'd3);
    flush = 1'b1; bd_in = 1'b1; exc_in = 5'd4;
    step();
    chk("fl_instr", {32'd0, a_instr}, 64'd0);
    chk("fl_valid", {63'd0, a_valid}, 64'd0);
    chk("fl_exc", {59'd0, a_exc}, 64'd0);
    chk("fl_pc", {32'd0, a_pc}, 64'h3010);
    chk("fl_bd", {63'd0, a_bd}, 64'd1);
    chk("fl_tnew", {62'd0, a_tnew}, 64'd0);
    chk("fl_wdata", {32'd0, a_wdata}, 64'd0);
    chk("fl_waddr", {59'd0, a_waddr}, 64'd0);
    chk("fl_regwrite", {63'd0, a_regwrite}, 64'd0);
    chk("fl_hold", {56'd0, a_hold}, 64'd0);
    chk("flb_pc", {32'd0, b_pc}, 64'd0);
    chk("flb_bd", {63'd0, b_bd}, 64'd0);
    chk("flb_instr", {32'd0, b_instr}, 64'd0);

    // flush while stalled still clears the counter
    en = 1'b0; flush = 1'b0; step(); step(); step();
    chk("fl2_pre", {56'd0, a_hold}, 64'd3);
    flush = 1'b1; pc_in = 32'h3020; bd_in = 1'b0;
    step();
    chk("fl2_hold", {56'd0, a_hold}, 64'd0);
    chk("fl2_pc", {32'd0, a_pc}, 64'h3020);
    flush = 1'b0;

    // async reset between edges after a 7-cycle hold
    drive_load(32'h00432021, 32'h3004, 5'd4, 32'hBEEF, 2'd2);
    step();
    en = 1'b0;
    repeat (7) step();
    chk("ar_pre_hold", {56'd0, a_hold}, 64'd7);
    #2 reset = 1'b1;
    #1;
    chk("ar_hold", {56'd0, a_hold}, 64'd0);
    chk("ar_instr", {32'd0, a_instr}, 64'd0);
    chk("ar_pc", {32'd0, a_pc}, 64'd0);
    chk("ar_valid", {63'd0, a_valid}, 64'd0);
    chk("ar_regwrite", {63'd0, a_regwrite}, 64'd0);
    chk("ar_wdata", {32'd0, a_wdata}, 64'd0);
    chk("ar_tnew", {62'd0, a_tnew}, 64'd0);
    chk("ar_c_wdata", c_wdata, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive_load(32'h2222_3333, 32'h3040, 5'd9, 32'h42, 2'd3);
    step();
    chk("post_rst_instr", {32'd0, a_instr}, 64'h2222_3333);
    chk("post_rst_tnew", {62'd0, a_tnew}, 64'd2);
    chk("post_rst_regwrite", {63'd0, a_regwrite}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
